// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus scheduler: state encoding,
// strobe polarity and default phase timings.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_STB,
    A_HLD,
    D_STB,
    D_HLD,
    REC
  } state_t;

  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

  localparam int PHASE_CYC_DEF = 10;
  localparam int REC_CYC_DEF   = 20;

endpackage

// File: rtl/rtc_bus_arbiter.sv
// Combinational winner select for the RTC bus scheduler. Defining
// RTC_BUS_RR_EN selects round-robin; otherwise fixed priority, index 0 highest.
module rtc_bus_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] win,
  output logic             win_any
);

  assign win_any = |req;

`ifdef RTC_BUS_RR_EN
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic             found;
  int               idx;

  // Search starts at the pointer and wraps; the first set request wins.
  always_comb begin
    win      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        ptr_next = PTR_W'((idx + 1) % N_REQ);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end
`else
  // Isolate the lowest set bit.
  assign win = req & ((~req) + N_REQ'(1));

  logic unused_ok;
  assign unused_ok = &{1'b0, clock, reset, advance};
`endif

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Owns the RTC multiplexed AD bus: arbitrates requesters and runs one
// address/data/recovery cycle per grant. RTC_BUS_RR_EN enables round-robin.
module rtc_bus_scheduler
  import rtc_bus_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int PHASE_CYC = PHASE_CYC_DEF,
  parameter int REC_CYC   = REC_CYC_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rnw,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         rdata,
  output logic               busy,
  output logic               ad_o,
  output logic               cs_o,
  output logic               rd_o,
  output logic               wr_o,
  output logic [7:0]         bus_out,
  output logic               bus_oe,
  input  logic [7:0]         bus_in
);

  localparam int CNT_MAX = (PHASE_CYC > REC_CYC) ? PHASE_CYC : REC_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] PHASE_LD = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(REC_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rnw;
  logic [7:0]       wdata;
  logic [N_REQ-1:0] win;
  logic             win_any;
  logic             advance;
  logic [7:0]       sel_addr;
  logic [7:0]       sel_wdata;
  logic             sel_rnw;

  assign advance = (state == IDLE) && win_any;

  rtc_bus_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .advance (advance),
    .req     (req),
    .win     (win),
    .win_any (win_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rnw   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        sel_addr  = sel_addr  | req_addr[8*i +: 8];
        sel_wdata = sel_wdata | req_wdata[8*i +: 8];
        sel_rnw   = sel_rnw   | req_rnw[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rnw     <= 1'b0;
      wdata   <= '0;
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      ad_o    <= 1'b1;
      cs_o    <= STB_OFF;
      rd_o    <= STB_OFF;
      wr_o    <= STB_OFF;
      bus_out <= '0;
      bus_oe  <= 1'b0;
    end else begin
      done <= '0;
      // A corrupted owner mid-cycle abandons the cycle rather than drive the bus blindly.
      if (state != IDLE && state != REC && !$onehot(gnt)) begin
        state  <= IDLE;
        gnt    <= '0;
        busy   <= 1'b0;
        ad_o   <= 1'b1;
        cs_o   <= STB_OFF;
        rd_o   <= STB_OFF;
        wr_o   <= STB_OFF;
        bus_oe <= 1'b0;
      end else if (state != IDLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (win_any) begin
              state   <= A_STB;
              cnt     <= PHASE_LD;
              gnt     <= win;
              busy    <= 1'b1;
              rnw     <= sel_rnw;
              wdata   <= sel_wdata;
              ad_o    <= 1'b0;
              cs_o    <= STB_ON;
              wr_o    <= STB_ON;
              bus_oe  <= 1'b1;
              bus_out <= sel_addr;
            end
          end
          A_STB: begin
            state <= A_HLD;
            cnt   <= PHASE_LD;
            wr_o  <= STB_OFF;
          end
          A_HLD: begin
            state <= D_STB;
            cnt   <= PHASE_LD;
            ad_o  <= 1'b1;
            if (rnw) begin
              rd_o   <= STB_ON;
              bus_oe <= 1'b0;
            end else begin
              wr_o    <= STB_ON;
              bus_out <= wdata;
            end
          end
          D_STB: begin
            state <= D_HLD;
            cnt   <= PHASE_LD;
            rd_o  <= STB_OFF;
            wr_o  <= STB_OFF;
            if (rnw) begin
              rdata <= bus_in;
            end
          end
          D_HLD: begin
            state  <= REC;
            cnt    <= REC_LD;
            cs_o   <= STB_OFF;
            bus_oe <= 1'b0;
            ad_o   <= 1'b1;
            done   <= gnt;
            gnt    <= '0;
          end
          REC: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
